mem_block_responder: RTL
========================

Name: mem_block_responder

Overview:
- Memory-side end of the cache miss interface: accepts a block-read request (16-bit address, valid/ready) from the cache's memory controller.
- After a programmable latency, streams the block back as BEATS_PER_BLOCK 32-bit beats with valid/ready flow control.
- Holds a small backing word store, preloadable through a write port. Serves as the memory model for cache-level benches and as the template for the real memory-side adapter.

Parameters:
- ADDR_WIDTH, 16, request address width (block address = {tag, set} zero-extended).
- DATA_WIDTH, 32, beat width.
- BEATS_PER_BLOCK, 10, beats per block (10 x 32 = 320-bit block).
- BLOCK_ADDR_BITS, 6, low address bits used to index the store; upper bits are ignored (aliasing).
- READ_LATENCY, 4, cycles from request accept to first beat valid; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_mem_req_addr  in  ADDR_WIDTH  requested block address
- i_mem_req_valid  in  1  request valid
- o_mem_req_ready  out  1  responder can accept a request
- o_mem_data  out  DATA_WIDTH  response beat
- o_mem_data_valid  out  1  beat valid
- i_mem_ready  in  1  requester accepts beat
- o_resp_last  out  1  current beat is final beat of block
- o_busy  out  1  request in progress
- i_wr_en  in  1  store write enable (preload)
- i_wr_addr  in  BLOCK_ADDR_BITS+4  word index = block*BEATS_PER_BLOCK + beat
- i_wr_data  in  DATA_WIDTH  store write data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high. The reset is sampled only on the rising edge of clk.
- Reset values of outputs:
  - o_mem_req_ready=1
  - o_mem_data=0
  - o_mem_data_valid=0
  - o_resp_last=0
  - o_busy=0
  - State=IDLE; counters = 0.
  - Store contents are NOT reset.
- Store: BEATS_PER_BLOCK x 2^BLOCK_ADDR_BITS words.
  - Write is synchronous; i_wr_en is honoured in every state.
  - Writes with i_wr_addr >= store depth are dropped.
- FSM IDLE:
  - o_mem_req_ready=1.
  - On i_mem_req_valid & o_mem_req_ready: latch block index = i_mem_req_addr[BLOCK_ADDR_BITS-1:0], set latency count to READ_LATENCY-1, go to WAIT.
  - o_busy=1 from the cycle after accept.
- FSM WAIT:
  - o_mem_req_ready=0.
  - Count down. At count 0, load o_mem_data with store[block*BEATS_PER_BLOCK+0], set o_mem_data_valid, go to STREAM.
  - Resulting latency: accept at edge T gives first valid visible after edge T+READ_LATENCY. With READ_LATENCY=1, valid is visible the cycle immediately after accept.
- FSM STREAM:
  - A beat transfers on o_mem_data_valid & i_mem_ready.
  - While i_mem_ready=0, o_mem_data, o_mem_data_valid and o_resp_last hold stable.
  - On a transfer of a non-final beat: increment the beat counter and load the next word the same edge. Valid stays high, giving back-to-back beats.
  - o_resp_last=1 exactly while beat index == BEATS_PER_BLOCK-1.
  - On a transfer of the last beat: drop valid and last, clear o_busy, return to IDLE. ready=1 on the next cycle.
- Read/write collision: the store read for a beat load happens at the load edge. A write to the same word on that edge presents the OLD value (read-before-write). Later beats see the new value.
- Requests while not IDLE are not accepted (ready=0). The requester must hold its request; nothing is queued.
- Beat index width is clog2(BEATS_PER_BLOCK). Word index is computed at full width with no truncation.
- rst asserted mid-WAIT or mid-STREAM: the next cycle returns to the reset values. Any partial block is abandoned with no further beats.

Optional Feature:
- Macro: MEM_BLOCK_RESPONDER_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on rst) advances every cycle in STREAM.
  - After each transferred non-final beat, if lfsr[0]==1 the next beat is withheld for one cycle (valid=0) before being presented.
  - This exercises gap tolerance in the requester. Beat order and data are unchanged.
- When undefined: no LFSR logic; beats are strictly back-to-back whenever i_mem_ready=1.

Test Plan:
- Preload store[b*10+k]=32'h0B00_0000|(b<<8)|k for all b, k. Request addr 16'h0003 with READ_LATENCY=4, i_mem_ready=1 -> valid first seen 4 cycles after accept; 10 consecutive beats 32'h0B00_0300..32'h0B00_0309; o_resp_last only on 32'h0B00_0309; ready=1 the cycle after.
- Same request with i_mem_ready toggling 1,0,0,1,... -> each beat held stable while ready=0; the sequence is still 0300..0309, with no beat lost or duplicated.
- Request addr 16'h0F43 (BLOCK_ADDR_BITS=6) -> returns block 3 data (aliasing). A second request with valid held during streaming is accepted only on the cycle after the last beat.
- While streaming block 5 beat 2, write store[5*10+2] on the load edge and write store[5*10+7] -> beat 2 shows the old value; beat 7 shows the new value.
- Assert rst for one cycle during beat 4 -> next cycle valid=0, busy=0, ready=1. A new request for block 1 returns correct data with full latency.
- With MEM_BLOCK_RESPONDER_STALL_EN defined -> data sequence identical to the first scenario, with at least one one-cycle valid gap inserted.

Source files
------------

// File: rtl/mem_block_responder.sv
// Memory-side block responder: accepts a block address and streams BEATS_PER_BLOCK words from a preloadable store.
// Latency: first beat is visible READ_LATENCY cycles after request accept; later beats follow back-to-back.
// Backpressure: beats hold while i_mem_ready=0, no request queueing. MEM_BLOCK_RESPONDER_STALL_EN adds LFSR beat gaps.
module mem_block_responder #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int BEATS_PER_BLOCK = 10,
    parameter int BLOCK_ADDR_BITS = 6,
    parameter int READ_LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        i_mem_req_addr,
    input  logic                         i_mem_req_valid,
    output logic                         o_mem_req_ready,
    output logic [DATA_WIDTH-1:0]        o_mem_data,
    output logic                         o_mem_data_valid,
    input  logic                         i_mem_ready,
    output logic                         o_resp_last,
    output logic                         o_busy,
    input  logic                         i_wr_en,
    input  logic [BLOCK_ADDR_BITS+3:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]        i_wr_data
);
    localparam int DEPTH  = BEATS_PER_BLOCK * (1 << BLOCK_ADDR_BITS);
    localparam int BEAT_W = $clog2(BEATS_PER_BLOCK);
    localparam int WA_W   = BLOCK_ADDR_BITS + 4;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_BLOCK - 1);
    localparam logic [WA_W:0]     DEPTH_W   = (WA_W + 1)'(DEPTH);
    localparam logic [7:0]        LAT_INIT  = 8'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

    state_t                     state;
    logic [DATA_WIDTH-1:0]      store [DEPTH];
    logic [BLOCK_ADDR_BITS-1:0] blk;
    logic [7:0]                 lat_cnt;
    logic [BEAT_W-1:0]          beat;
    logic [BEAT_W-1:0]          rd_beat;
    logic [WA_W-1:0]            rd_idx;
    logic [DATA_WIDTH-1:0]      rd_word;
    logic                       unused_addr_hi;
`ifdef MEM_BLOCK_RESPONDER_STALL_EN
    logic [7:0]                 lfsr;
`endif

    assign unused_addr_hi = ^i_mem_req_addr[ADDR_WIDTH-1:BLOCK_ADDR_BITS];

    // While a beat is presented the store is addressed at the following beat; otherwise at the current one.
    assign rd_beat = (state == STREAM && o_mem_data_valid) ? beat + 1'b1 : beat;
    assign rd_idx  = WA_W'(blk) * WA_W'(BEATS_PER_BLOCK) + WA_W'(rd_beat);
    assign rd_word = store[rd_idx];

    always_ff @(posedge clk) begin
        if (i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W)) begin
            store[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            o_mem_req_ready  <= 1'b1;
            o_mem_data       <= '0;
            o_mem_data_valid <= 1'b0;
            o_resp_last      <= 1'b0;
            o_busy           <= 1'b0;
            blk              <= '0;
            lat_cnt          <= '0;
            beat             <= '0;
`ifdef MEM_BLOCK_RESPONDER_STALL_EN
            lfsr             <= 8'hA5;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_mem_req_valid && o_mem_req_ready) begin
                        blk             <= i_mem_req_addr[BLOCK_ADDR_BITS-1:0];
                        lat_cnt         <= LAT_INIT;
                        beat            <= '0;
                        o_mem_req_ready <= 1'b0;
                        o_busy          <= 1'b1;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 8'd0) begin
                        o_mem_data       <= rd_word;
                        o_mem_data_valid <= 1'b1;
                        o_resp_last      <= (rd_beat == LAST_BEAT);
                        state            <= STREAM;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                STREAM: begin
`ifdef MEM_BLOCK_RESPONDER_STALL_EN
                    lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
                    if (o_mem_data_valid && i_mem_ready) begin
                        if (o_resp_last) begin
                            o_mem_data_valid <= 1'b0;
                            o_resp_last      <= 1'b0;
                            o_busy           <= 1'b0;
                            o_mem_req_ready  <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            beat <= rd_beat;
`ifdef MEM_BLOCK_RESPONDER_STALL_EN
                            // A withheld beat is fetched on the gap cycle, so data order is unaffected.
                            if (lfsr[0]) begin
                                o_mem_data_valid <= 1'b0;
                                o_resp_last      <= 1'b0;
                            end else begin
                                o_mem_data  <= rd_word;
                                o_resp_last <= (rd_beat == LAST_BEAT);
                            end
`else
                            o_mem_data  <= rd_word;
                            o_resp_last <= (rd_beat == LAST_BEAT);
`endif
                        end
                    end
`ifdef MEM_BLOCK_RESPONDER_STALL_EN
                    else if (!o_mem_data_valid) begin
                        o_mem_data       <= rd_word;
                        o_mem_data_valid <= 1'b1;
                        o_resp_last      <= (rd_beat == LAST_BEAT);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
